// File: rtl/pc_sequencer_if.sv
// Handshake and control bundle between pc_sequencer (master) and its datapath/memories (slave).
// SINGLE_STEP_EN adds the step input.
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             imem_ready;
    logic             dmem_ready;
    logic [2:0]       op_class;
    logic             cond_true;
`ifdef SINGLE_STEP_EN
    logic             step;
`endif
    logic             imem_rd;
    logic             ir_load;
    logic             dmem_rd;
    logic             dmem_wr;
    logic             rf_we;
    logic [1:0]       pc_en;
    logic             halted;
    logic             fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
`ifdef SINGLE_STEP_EN
        input  step,
`endif
        input  run, imem_ready, dmem_ready, op_class, cond_true,
        output imem_rd, ir_load, dmem_rd, dmem_wr, rf_we, pc_en,
        output halted, fault, state, instr_count
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        output step,
`endif
        output run, imem_ready, dmem_ready, op_class, cond_true,
        input  imem_rd, ir_load, dmem_rd, dmem_wr, rf_we, pc_en,
        input  halted, fault, state, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM with memory-ready timeouts and a saturating
// retired-instruction counter. Optional SINGLE_STEP_EN adds step-by-step execution.
module pc_sequencer #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_e;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;
    localparam logic [1:0] PC_ADD  = 2'b11;

    localparam logic [2:0] OP_ALU    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_JUMP   = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;
    localparam logic [2:0] OP_HALT   = 3'b101;

    // The stall that would bring the count up to MAX_WAIT is the one that faults.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    logic [2:0]       opc_q, opc_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       imem_rd, ir_load, dmem_rd, dmem_wr, rf_we;
    logic [1:0] pc_en;
    logic       retire;
    logic       start;

`ifdef SINGLE_STEP_EN
    assign start = bus.run | bus.step;
`else
    assign start = bus.run;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d = state_q;
        opc_d   = opc_q;
        wait_d  = wait_q;
        imem_rd = 1'b0;
        ir_load = 1'b0;
        dmem_rd = 1'b0;
        dmem_wr = 1'b0;
        rf_we   = 1'b0;
        pc_en   = PC_HOLD;

        unique case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                imem_rd = 1'b1;
                if (bus.imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                opc_d   = bus.op_class;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                unique case (opc_q)
                    OP_ALU:            state_d = S_WB;
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_JUMP: begin
                        pc_en   = PC_LOAD;
                        state_d = S_FETCH;
                    end
                    OP_BRANCH: begin
                        pc_en   = bus.cond_true ? PC_ADD : PC_INC;
                        state_d = S_FETCH;
                    end
                    OP_HALT:           state_d = S_HALT;
                    default:           state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                dmem_rd = (opc_q == OP_LOAD);
                dmem_wr = (opc_q != OP_LOAD);
                if (bus.dmem_ready) begin
                    if (opc_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_en   = PC_INC;
                        state_d = S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_en   = PC_INC;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    pc_en   = PC_INC;
                    state_d = S_FETCH;
                end
            end
            S_FAULT: ;
        endcase

`ifdef SINGLE_STEP_EN
        // A nonzero pc_en on the way to FETCH marks a retirement; without run, park in IDLE.
        if (state_d == S_FETCH && pc_en != PC_HOLD && !bus.run) state_d = S_IDLE;
`endif

        if (state_d != state_q) wait_d = '0;

        retire = (pc_en != PC_HOLD) || (state_q == S_EXEC && opc_q == OP_HALT);
        cnt_d  = (retire && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

        if (reset) begin
            imem_rd = 1'b0;
            ir_load = 1'b0;
            dmem_rd = 1'b0;
            dmem_wr = 1'b0;
            rf_we   = 1'b0;
            pc_en   = PC_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_rd     = imem_rd;
    assign bus.ir_load     = ir_load;
    assign bus.dmem_rd     = dmem_rd;
    assign bus.dmem_wr     = dmem_wr;
    assign bus.rf_we       = rf_we;
    assign bus.pc_en       = pc_en;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fault       = (state_q == S_FAULT);
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: two instances (default and CNT_W=4/MAX_WAIT=2) share stimulus
// and are compared against an instruction-level reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_pc_sequencer;
    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3;
    localparam int ST_MEM = 4, ST_WB = 5, ST_HALT = 6, ST_FAULT = 7;
    localparam int OP_ALU = 0, OP_LOAD = 1, OP_STORE = 2, OP_JUMP = 3, OP_BRANCH = 4, OP_HALT = 5;

    typedef struct packed {
        logic [2:0] state;
        logic       halted;
        logic       fault;
        logic [1:0] pc_en;
        logic       rf_we;
        logic       dmem_wr;
        logic       dmem_rd;
        logic       ir_load;
        logic       imem_rd;
    } exp_t;

    typedef struct {
        int st;
        int opc;
        int stalls;
        int retired;
    } mdl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0, cond_true = 1'b0;
    logic [2:0] op_class = 3'd0;
    int         n_cmp = 0, n_bad = 0;
    mdl_t       ma, mb;
    exp_t       obs_a, obs_b;

    pc_sequencer_if #(.CNT_W(16)) bus_a ();
    pc_sequencer_if #(.CNT_W(4))  bus_b ();

    assign bus_a.run = run;               assign bus_b.run = run;
    assign bus_a.imem_ready = imem_ready; assign bus_b.imem_ready = imem_ready;
    assign bus_a.dmem_ready = dmem_ready; assign bus_b.dmem_ready = dmem_ready;
    assign bus_a.op_class = op_class;     assign bus_b.op_class = op_class;
    assign bus_a.cond_true = cond_true;   assign bus_b.cond_true = cond_true;
`ifdef SINGLE_STEP_EN
    assign bus_a.step = 1'b0;             assign bus_b.step = 1'b0;
`endif

    pc_sequencer #(.CNT_W(16), .MAX_WAIT(15)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    pc_sequencer #(.CNT_W(4),  .MAX_WAIT(2))  u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    assign obs_a = {bus_a.state, bus_a.halted, bus_a.fault, bus_a.pc_en, bus_a.rf_we,
                    bus_a.dmem_wr, bus_a.dmem_rd, bus_a.ir_load, bus_a.imem_rd};
    assign obs_b = {bus_b.state, bus_b.halted, bus_b.fault, bus_b.pc_en, bus_b.rf_we,
                    bus_b.dmem_wr, bus_b.dmem_rd, bus_b.ir_load, bus_b.imem_rd};

    // Expected outputs this cycle, from the model's position and the current inputs.
    function automatic exp_t model_out(input mdl_t m);
        exp_t e = '0;
        e.state  = 3'(m.st);
        e.halted = (m.st == ST_HALT);
        e.fault  = (m.st == ST_FAULT);
        if (reset) return e;
        case (m.st)
            ST_FETCH: begin e.imem_rd = 1'b1; e.ir_load = imem_ready; end
            ST_EXEC:
                if (m.opc == OP_JUMP) e.pc_en = 2'b10;
                else if (m.opc == OP_BRANCH) e.pc_en = cond_true ? 2'b11 : 2'b01;
            ST_MEM: begin
                e.dmem_rd = (m.opc == OP_LOAD);
                e.dmem_wr = (m.opc == OP_STORE);
                if (dmem_ready && m.opc == OP_STORE) e.pc_en = 2'b01;
            end
            ST_WB:   begin e.rf_we = 1'b1; e.pc_en = 2'b01; end
            ST_HALT: if (run) e.pc_en = 2'b01;
            default: ;
        endcase
        return e;
    endfunction

    function automatic mdl_t model_next(input mdl_t m, input int max_wait);
        mdl_t n = m;
        exp_t e = model_out(m);
        if (reset) return '{st: ST_IDLE, opc: 0, stalls: 0, retired: 0};
        if (e.pc_en != 2'b00 || (m.st == ST_EXEC && m.opc == OP_HALT)) n.retired++;
        case (m.st)
            ST_IDLE:   if (run) n.st = ST_FETCH;
            ST_FETCH:
                if (imem_ready) n.st = ST_DECODE;
                else begin n.stalls++; if (n.stalls == max_wait) n.st = ST_FAULT; end
            ST_DECODE: begin n.opc = int'(op_class); n.st = ST_EXEC; end
            ST_EXEC:
                case (m.opc)
                    OP_ALU:              n.st = ST_WB;
                    OP_LOAD, OP_STORE:   n.st = ST_MEM;
                    OP_JUMP, OP_BRANCH:  n.st = ST_FETCH;
                    OP_HALT:             n.st = ST_HALT;
                    default:             n.st = ST_FAULT;
                endcase
            ST_MEM:
                if (dmem_ready) n.st = (m.opc == OP_LOAD) ? ST_WB : ST_FETCH;
                else begin n.stalls++; if (n.stalls == max_wait) n.st = ST_FAULT; end
            ST_WB:     n.st = ST_FETCH;
            ST_HALT:   if (run) n.st = ST_FETCH;
            default:   ;
        endcase
        if (n.st != m.st) n.stalls = 0;
        return n;
    endfunction

    function automatic int sat(input int r, input int w);
        int cap = (1 << w) - 1;
        return (r > cap) ? cap : r;
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            ma = model_next(ma, 15);
            mb = model_next(mb, 2);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        cond_true = 1'b0; op_class = 3'd0;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        cyc(2);
        @(negedge clk);
        n_cmp++;
        if (obs_a !== exp_t'(0)) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", obs_a);
        end
        n_cmp++;
        if (bus_a.instr_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_count: got %0d want 0", bus_a.instr_count);
        end
        n_cmp++;
        if (obs_b !== exp_t'(0)) begin
            n_bad++; $display("FAIL reset_outputs_b: got %h want 0", obs_b);
        end
        do_reset();
    endtask

    task automatic test_alu();
        int exp_st[6] = '{0, 1, 2, 3, 5, 1};
        do_reset();
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; op_class = 3'(OP_ALU);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_a.state !== 3'(exp_st[i])) begin
                n_bad++; $display("FAIL alu_state[%0d]: got %0d want %0d", i, bus_a.state, exp_st[i]);
            end
            n_cmp++;
            if ({bus_a.rf_we, bus_a.pc_en} !== ((i == 4) ? 3'b101 : 3'b000)) begin
                n_bad++; $display("FAIL alu_wb[%0d]: got %b", i, {bus_a.rf_we, bus_a.pc_en});
            end
            if (i < 5) cyc(1);
        end
        n_cmp++;
        if (bus_a.instr_count !== 16'd1) begin
            n_bad++; $display("FAIL alu_count: got %0d want 1", bus_a.instr_count);
        end
    endtask

    task automatic test_branch();
        logic [1:0] exp_pc[8] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
        do_reset();
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; op_class = 3'(OP_BRANCH);
        for (int i = 0; i < 8; i++) begin
            cond_true = (i < 4);
            @(negedge clk);
            n_cmp++;
            if ({bus_a.rf_we, bus_a.pc_en} !== {1'b0, exp_pc[i]}) begin
                n_bad++; $display("FAIL branch_pc[%0d]: got %b want 0%b", i, {bus_a.rf_we, bus_a.pc_en}, exp_pc[i]);
            end
            if (i < 7) cyc(1);
        end
        n_cmp++;
        if (bus_a.instr_count !== 16'd2) begin
            n_bad++; $display("FAIL branch_count: got %0d want 2", bus_a.instr_count);
        end
    endtask

    task automatic test_load_stall();
        int exp_a[10] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 1};
        int exp_b[10] = '{0, 1, 2, 3, 4, 4, 7, 7, 7, 7};
        do_reset();
        run = 1'b1; imem_ready = 1'b1; op_class = 3'(OP_LOAD);
        for (int i = 0; i < 10; i++) begin
            dmem_ready = (i >= 7);
            @(negedge clk);
            n_cmp++;
            if (bus_a.state !== 3'(exp_a[i]) || bus_a.dmem_rd !== (i >= 4 && i <= 7) ||
                bus_a.rf_we !== (i == 8)) begin
                n_bad++; $display("FAIL load_a[%0d]: got st=%0d rd=%b we=%b want st=%0d",
                                  i, bus_a.state, bus_a.dmem_rd, bus_a.rf_we, exp_a[i]);
            end
            n_cmp++;
            if (bus_b.state !== 3'(exp_b[i]) || (i >= 6 && (obs_b[6:0] !== 7'd0 || bus_b.fault !== 1'b1))) begin
                n_bad++; $display("FAIL load_timeout_b[%0d]: got %h want st=%0d", i, obs_b, exp_b[i]);
            end
            cyc(1);
        end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus_b.state !== 3'd0 || bus_b.fault !== 1'b0) begin
            n_bad++; $display("FAIL fault_exit_b: got st=%0d fault=%b want 0/0", bus_b.state, bus_b.fault);
        end
    endtask

    task automatic test_halt();
        do_reset();
        imem_ready = 1'b1; dmem_ready = 1'b1; op_class = 3'(OP_HALT);
        for (int i = 0; i < 16; i++) begin
            run = (i < 2) || (i == 14);
            @(negedge clk);
            if (i >= 4 && i <= 13) begin
                n_cmp++;
                if ({bus_a.halted, bus_a.pc_en, bus_a.state} !== 6'b1_00_110 || bus_a.instr_count !== 16'd1) begin
                    n_bad++; $display("FAIL halt_hold[%0d]: got h=%b pc=%b st=%0d cnt=%0d want 1/00/6/1",
                                      i, bus_a.halted, bus_a.pc_en, bus_a.state, bus_a.instr_count);
                end
            end
            if (i == 14) begin
                n_cmp++;
                if (bus_a.pc_en !== 2'b01 || bus_a.state !== 3'd6) begin
                    n_bad++; $display("FAIL halt_resume: got pc=%b st=%0d want 01/6", bus_a.pc_en, bus_a.state);
                end
            end
            if (i == 15) begin
                n_cmp++;
                if (bus_a.state !== 3'd1 || bus_a.halted !== 1'b0 || bus_a.instr_count !== 16'd2) begin
                    n_bad++; $display("FAIL halt_after: got st=%0d h=%b cnt=%0d want 1/0/2",
                                      bus_a.state, bus_a.halted, bus_a.instr_count);
                end
            end
            cyc(1);
        end
    endtask

    task automatic test_illegal_and_reset();
        do_reset();
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; op_class = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 4) begin
                n_cmp++;
                if (bus_a.state !== 3'd7 || bus_a.fault !== 1'b1 || obs_a[6:0] !== 7'd0) begin
                    n_bad++; $display("FAIL illegal_fault[%0d]: got %h want st=7 fault=1", i, obs_a);
                end
            end
            cyc(1);
        end
        do_reset();
        run = 1'b1; op_class = 3'(OP_ALU);
        for (int i = 0; i < 7; i++) begin
            imem_ready = (i < 5);
            @(negedge clk);
            if (i < 6) cyc(1);
        end
        n_cmp++;
        if (bus_a.imem_rd !== 1'b1 || bus_a.state !== 3'd1 || bus_a.instr_count !== 16'd1) begin
            n_bad++; $display("FAIL wait_before_reset: got rd=%b st=%0d cnt=%0d want 1/1/1",
                              bus_a.imem_rd, bus_a.state, bus_a.instr_count);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (obs_a[6:0] !== 7'd0) begin
            n_bad++; $display("FAIL reset_comb_strobes: got %b want 0", obs_a[6:0]);
        end
        cyc(1);
        @(negedge clk);
        n_cmp++;
        if (bus_a.state !== 3'd0 || bus_a.instr_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_mid_wait: got st=%0d cnt=%0d want 0/0", bus_a.state, bus_a.instr_count);
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_saturate();
        do_reset();
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; op_class = 3'(OP_ALU);
        cyc(1 + 17 * 4);
        @(negedge clk);
        n_cmp++;
        if (bus_b.instr_count !== 4'hF) begin
            n_bad++; $display("FAIL saturate_b: got %0d want 15", bus_b.instr_count);
        end
        n_cmp++;
        if (bus_a.instr_count !== 16'd17) begin
            n_bad++; $display("FAIL count_17_a: got %0d want 17", bus_a.instr_count);
        end
    endtask

    task automatic test_random();
        int dry = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (dry == 0 && $urandom_range(0, 99) == 0) dry = 20;
            reset      = ($urandom_range(0, 149) == 0);
            run        = ($urandom_range(0, 3) != 0);
            imem_ready = (dry == 0) && ($urandom_range(0, 3) != 0);
            dmem_ready = (dry == 0) && ($urandom_range(0, 2) != 0);
            cond_true  = 1'($urandom_range(0, 1));
            op_class   = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            if (dry > 0) dry--;
            @(negedge clk);
            n_cmp++;
            if (obs_a !== model_out(ma)) begin
                n_bad++; $display("FAIL rand_out_a cyc %0d: got %h want %h", c, obs_a, model_out(ma));
            end
            n_cmp++;
            if (obs_b !== model_out(mb)) begin
                n_bad++; $display("FAIL rand_out_b cyc %0d: got %h want %h", c, obs_b, model_out(mb));
            end
            n_cmp++;
            if (bus_a.instr_count !== 16'(sat(ma.retired, 16))) begin
                n_bad++; $display("FAIL rand_cnt_a cyc %0d: got %0d want %0d", c, bus_a.instr_count, sat(ma.retired, 16));
            end
            n_cmp++;
            if (bus_b.instr_count !== 4'(sat(mb.retired, 4))) begin
                n_bad++; $display("FAIL rand_cnt_b cyc %0d: got %0d want %0d", c, bus_b.instr_count, sat(mb.retired, 4));
            end
            cyc(1);
        end
    endtask

    initial begin
        ma = '{st: 0, opc: 0, stalls: 0, retired: 0};
        mb = '{st: 0, opc: 0, stalls: 0, retired: 0};
        #1;
        test_reset();
        test_alu();
        test_branch();
        test_load_stall();
        test_halt();
        test_illegal_and_reset();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control FSM that sequences the program counter and the fetch/execute datapath of the processor. It drives the 2-bit PC enable code (00 hold, 01 increment, 10 load absolute address, 11 add displacement) and issues the instruction-fetch, data-memory and register-file write strobes. It also handles the memory-ready handshakes, halt/resume, fault detection and a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter instr_count
MAX_WAIT, 15, cycles a memory handshake may stall before FAULT (1..255)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high reset
run  input  1  start from IDLE / resume from HALT
imem_ready  input  1  instruction memory data valid
dmem_ready  input  1  data memory access complete
op_class  input  3  decoded class of IR: 000 ALU, 001 LOAD, 010 STORE, 011 JUMP, 100 BRANCH, 101 HALT, 110/111 illegal
cond_true  input  1  branch condition result from flags
imem_rd  output  1  instruction fetch request
ir_load  output  1  load instruction register
dmem_rd  output  1  data memory read request
dmem_wr  output  1  data memory write request
rf_we  output  1  register file write enable
pc_en  output  2  PC control code to program counter
halted  output  1  FSM in HALT
fault  output  1  FSM in FAULT
state  output  3  current state encoding (debug)
instr_count  output  CNT_W  retired instructions, saturating

Behaviour:
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6, FAULT 7.
- Reset: state=IDLE, opc_q=000, wait_cnt=0, instr_count=0. While reset=1, all strobes and pc_en are forced to 0 combinationally. Reset mid-access abandons the access; there is no completion.
- Strobes/pc_en are combinational from state, opc_q and inputs. halted/fault/state decode state only.
- IDLE: run=1 -> FETCH, else stay.
- FETCH: imem_rd=1. If imem_ready=1: ir_load=1, -> DECODE. If imem_ready=0: wait_cnt++. When wait_cnt reaches MAX_WAIT -> FAULT.
- DECODE: one cycle. opc_q <= op_class. -> EXEC.
- EXEC, on opc_q:
  - ALU -> WB.
  - LOAD/STORE -> MEM.
  - JUMP: pc_en=10, -> FETCH.
  - BRANCH: pc_en = cond_true ? 11 : 01, -> FETCH.
  - HALT: pc_en=00, -> HALT.
  - 110/111 -> FAULT, pc_en=00.
- MEM: dmem_rd=1 (LOAD) or dmem_wr=1 (STORE), held until dmem_ready=1. Ready already high on entry completes in 1 cycle. On ready: LOAD -> WB; STORE: pc_en=01, -> FETCH. Timeout rule is the same as FETCH.
- WB: rf_we=1, pc_en=01, -> FETCH.
- HALT: halted=1, pc_en=00 (PC holds at halt instruction). run=1: pc_en=01, -> FETCH.
- FAULT: fault=1, all strobes 0. Only reset exits.
- wait_cnt clears on every state change. Only one handshake is outstanding at a time.
- Retirement = any cycle with pc_en != 00, plus the EXEC cycle of a HALT instruction. instr_count increments by 1 per retirement and saturates at all-ones (no wrap).
- pc_en is never 10/11 outside EXEC. At most one of imem_rd/dmem_rd/dmem_wr is high in any cycle.
- Each instruction takes ALU 4, JUMP/BRANCH 3, LOAD 5, STORE 4 cycles, assuming zero-wait memory.

Optional Feature:
SINGLE_STEP_EN: when defined, adds input step (1 bit). Every transition to FETCH that follows a retirement goes to IDLE instead if run=0. In IDLE, run=1 or step=1 -> FETCH. The HALT resume condition becomes run|step. Without the macro, step does not exist and retirement always returns to FETCH.

Test Plan:
- Reset, run=1, ALU op, zero-wait memory -> state 0,1,2,3,5,1. rf_we and pc_en=01 in the WB cycle only. instr_count=1.
- BRANCH with cond_true=1, then BRANCH with cond_true=0 -> pc_en=11 then 01 in the respective EXEC cycles. No rf_we. instr_count +2.
- LOAD with dmem_ready low 3 cycles -> dmem_rd high 4 cycles, then WB with rf_we=1. Same test with MAX_WAIT=2 -> fault=1, state=7, strobes 0 until reset.
- HALT op -> halted=1, pc_en=00, count +1. Hold run=0 10 cycles, stays. Pulse run=1 -> pc_en=01 one cycle, state=FETCH.
- op_class=111 -> FAULT after EXEC. Reset asserted during FETCH wait -> imem_rd=0 same cycle, state=IDLE next edge, instr_count=0.
- CNT_W=4, run 17 ALU ops -> instr_count saturates at 15.
